// File: rtl/popcount_pkg.sv
// Shared types and sizing helpers for the popcount engine.
// Also imported by benches that need PASSES / OUT_W for a given configuration.
package popcount_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    DONE
  } state_t;

  // Guarded against chunk<1 so an illegal configuration reaches the elaboration check cleanly.
  function automatic int calc_passes(input int width, input int chunk);
    if (chunk < 1) return 1;
    return (width + chunk - 1) / chunk;
  endfunction

  function automatic int calc_out_w(input int width);
    return $clog2(width + 1);
  endfunction

  function automatic int calc_pass_w(input int passes);
    return (passes > 1) ? $clog2(passes) : 1;
  endfunction

endpackage

// File: rtl/chunk_popcount.sv
// Combinational adder tree counting the set bits of a CHUNK-bit slice.
module chunk_popcount #(
  parameter int CHUNK = 8,
  parameter int OUT_W = 6
) (
  input  logic [CHUNK-1:0] slice,
  output logic [OUT_W-1:0] count
);

  localparam int LEAVES = 2 ** $clog2(CHUNK);

  // Heap-ordered tree: node[1] is the root, leaves sit at node[LEAVES +: LEAVES].
  logic [OUT_W-1:0] node [1:2*LEAVES-1];

  for (genvar i = 0; i < LEAVES; i++) begin : g_leaf
    if (i < CHUNK) begin : g_bit
      assign node[LEAVES+i] = OUT_W'(slice[i]);
    end else begin : g_pad
      assign node[LEAVES+i] = '0;
    end
  end

  for (genvar n = 1; n < LEAVES; n++) begin : g_sum
    assign node[n] = node[2*n] + node[2*n+1];
  end

  assign count = node[1];

endmodule

// File: rtl/popcount_engine.sv
// Handshaked multi-cycle population counter, CHUNK bits per COUNT cycle.
// Optional early termination on an all-zero remainder: define POPCOUNT_EARLY_EXIT_EN.
module popcount_engine
  import popcount_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int CHUNK = 8,
  localparam int OUT_W = calc_out_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out,
  output logic             busy
);

  localparam int PASSES = calc_passes(WIDTH, CHUNK);
  localparam int PASS_W = calc_pass_w(PASSES);

  if (WIDTH < 1 || CHUNK < 1 || CHUNK > WIDTH) begin : g_bad_cfg
    $fatal(1, "popcount_engine: illegal WIDTH/CHUNK combination");
  end

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  num_q, num_d;
  logic [OUT_W-1:0]  ctr_q, ctr_d;
  logic [PASS_W-1:0] pass_q, pass_d;

  logic [OUT_W-1:0]  chunk_cnt;
  logic [WIDTH-1:0]  num_shift;
  logic              last_pass;

  chunk_popcount #(
    .CHUNK (CHUNK),
    .OUT_W (OUT_W)
  ) u_chunk (
    .slice (num_q[CHUNK-1:0]),
    .count (chunk_cnt)
  );

  assign num_shift = num_q >> CHUNK;

`ifdef POPCOUNT_EARLY_EXIT_EN
  assign last_pass = (pass_q == PASS_W'(PASSES - 1)) || (num_shift == '0);
`else
  assign last_pass = (pass_q == PASS_W'(PASSES - 1));
`endif

  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    ctr_d   = ctr_q;
    pass_d  = pass_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          num_d   = in;
          ctr_d   = '0;
          pass_d  = '0;
          state_d = COUNT;
        end
      end
      COUNT: begin
        ctr_d  = ctr_q + chunk_cnt;
        num_d  = num_shift;
        pass_d = pass_q + PASS_W'(1);
        if (last_pass) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      num_q   <= '0;
      ctr_q   <= '0;
      pass_q  <= '0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      ctr_q   <= ctr_d;
      pass_q  <= pass_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out       = ctr_q;

endmodule

// File: tb/tb_popcount_engine.sv
// Directed bench for popcount_engine: a 32/8 instance and a 10/4 instance on one clock.
module tb_popcount_engine;
  import popcount_pkg::*;

`ifdef POPCOUNT_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
  logic [31:0] a_in;
  logic [5:0]  a_out;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
  logic [9:0]  b_in;
  logic [3:0]  b_out;

  int total = 0;
  int bad   = 0;

  popcount_engine #(.WIDTH(32), .CHUNK(8)) u_dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in(a_in),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out(a_out),
    .busy(a_busy)
  );

  popcount_engine #(.WIDTH(10), .CHUNK(4)) u_dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in(b_in),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out(b_out),
    .busy(b_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Latency model for the 10/4 instance: highest nonzero chunk index + 1, or fixed 3 passes.
  function automatic int exp_k_b(input logic [9:0] w);
    int k;
    if (!EE) return 3;
    k = 1;
    for (int c = 0; c < 3; c++)
      if (((w >> (c * 4)) & 10'h00F) != 10'h000) k = c + 1;
    return k;
  endfunction

  task automatic run_a(input logic [31:0] w, input int exp_cnt, input int exp_k);
    int k;
    @(negedge clk);
    check("a_in_ready_pre", a_in_ready, 1);
    a_in = w; a_in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_in_valid = 1'b0; a_in = ~w;
    k = 0;
    while (!a_out_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("a_latency", k, exp_k);
    check("a_out", a_out, exp_cnt);
    check("a_busy_done", a_busy, 1);
    a_out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_out_ready = 1'b0;
    check("a_in_ready_post", a_in_ready, 1);
    check("a_out_valid_post", a_out_valid, 0);
  endtask

  task automatic run_b(input logic [9:0] w, input int exp_cnt, input int exp_k);
    int k;
    @(negedge clk);
    check("b_in_ready_pre", b_in_ready, 1);
    b_in = w; b_in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b_in_valid = 1'b0; b_in = ~w;
    k = 0;
    while (!b_out_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("b_latency", k, exp_k);
    check("b_out", b_out, exp_cnt);
    check("b_busy_done", b_busy, 1);
    @(posedge clk);
    @(negedge clk);
    check("b_in_ready_post", b_in_ready, 1);
  endtask

  initial begin
    int k;
    bit seen_valid;
    logic [9:0] w;

    rst = 1'b1;
    a_in_valid = 1'b0; a_in = '0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in = '0; b_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", a_in_ready, 1);
    check("rst_out_valid", a_out_valid, 0);
    check("rst_busy", a_busy, 0);
    check("rst_out", a_out, 0);
    check("rst_b_busy", b_busy, 0);
    check("rst_b_out", b_out, 0);
    rst = 1'b0;

    run_a(32'hFFFF_FFFF, 32, 4);
    run_a(32'h0000_0001, 1, EE ? 1 : 4);
    run_a(32'h0000_0000, 0, EE ? 1 : 4);
    run_a(32'h00F0_0000, 4, EE ? 3 : 4);

    // Backpressure with a competing in_valid while the result is held.
    @(negedge clk);
    a_in = 32'h8000_0F0F; a_in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_in_valid = 1'b0;
    k = 0;
    while (!a_out_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("bp_latency", k, 4);
    for (int i = 0; i < 5; i++) begin
      a_in_valid = 1'b1; a_in = 32'h0000_1234;
      check("bp_out", a_out, 9);
      check("bp_out_valid", a_out_valid, 1);
      check("bp_in_ready", a_in_ready, 0);
      @(negedge clk);
    end
    a_in_valid = 1'b0;
    check("bp_out_final", a_out, 9);
    a_out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_out_ready = 1'b0;
    check("bp_idle_in_ready", a_in_ready, 1);
    check("bp_idle_busy", a_busy, 0);
    @(negedge clk);
    check("bp_not_accepted", a_busy, 0);

    // Reset during the second COUNT cycle discards the word.
    a_in = 32'hFFFF_FFFF; a_in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_busy", a_busy, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("mid_in_ready", a_in_ready, 1);
    check("mid_busy_after", a_busy, 0);
    check("mid_out", a_out, 0);
    seen_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (a_out_valid) seen_valid = 1'b1;
      @(negedge clk);
    end
    check("mid_no_valid", seen_valid, 0);
    run_a(32'h0000_00FF, 8, EE ? 1 : 4);

    run_b(10'h3FF, 10, 3);
    run_b(10'h000, 0, exp_k_b(10'h000));
    run_b(10'h00F, 4, exp_k_b(10'h00F));
    for (int i = 0; i < 16; i++) begin
      w = 10'($urandom_range(0, 1023));
      run_b(w, $countones(w), exp_k_b(w));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
